// File: rtl/stream_pkg.sv
// Shared definitions for the round-robin stream merge: channel-index sizing,
// the merged stream word record and the no-lock constant.
package stream_pkg;

    // A single grant per word gives plain round-robin.
    localparam int LOCK_NONE = 1;

    // Width of a channel index; never less than one bit.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Merged word at the default configuration (32-bit data, up to 16 channels).
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  chan;
    } stream_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: picks the first requester after 'last',
// wrapping modulo N_CH. Purely combinational.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] last,
    output logic [CH_W-1:0] g,
    output logic            valid
);

    logic [CH_W-1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        g     = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N_CH; k >= 1; k--) begin
            idx = CH_W'((int'(last) + k) % N_CH);
            if (req[idx]) begin
                g     = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_rr_merge.sv
// N-channel stb/ack stream merge with round-robin grant, optional burst lock,
// and a sticky exception that records the first faulting channel.
module stream_rr_merge
    import stream_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int WIDTH      = 32,
    parameter int LOCK_WORDS = LOCK_NONE,
    parameter int CH_W       = ch_w(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] input_data,
    input  logic [N_CH-1:0]       input_stb,
    output logic [N_CH-1:0]       input_ack,
    output logic [WIDTH-1:0]      output_data,
    output logic [CH_W-1:0]       output_chan,
    output logic                  output_stb,
    input  logic                  output_ack,
    input  logic [N_CH-1:0]       exception_in,
    input  logic                  exception_clear,
    output logic                  exception,
    output logic [CH_W-1:0]       exception_src
);

    localparam int CNT_W = $clog2(LOCK_WORDS + 1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CH_W-1:0]  chan;
    } word_t;

    logic [N_CH-1:0][WIDTH-1:0] in_words;
    word_t                      out_q;
    logic                       full;
    logic [CH_W-1:0]            last;
    logic                       lock;
    logic [CNT_W-1:0]           lock_cnt;
    logic [CH_W-1:0]            rr_g;
    logic                       rr_valid;
    logic [CH_W-1:0]            grant;
    logic                       grant_valid;
    logic                       accept;
    logic [CH_W-1:0]            low_idx;

    assign in_words = input_data;

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req   (input_stb),
        .last  (last),
        .g     (rr_g),
        .valid (rr_valid)
    );

    // While locked the burst owner keeps the grant even with its stb low;
    // 'last' already holds the owner because it follows every accept.
    always_comb begin
        grant       = lock ? last : rr_g;
        grant_valid = rst && (lock || rr_valid);
        accept      = grant_valid && input_stb[grant] && (!full || output_ack);
    end

    always_comb begin
        input_ack        = '0;
        input_ack[grant] = accept;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full  <= 1'b0;
            out_q <= '0;
            last  <= CH_W'(N_CH - 1);
        end else if (accept) begin
            full       <= 1'b1;
            out_q.data <= in_words[grant];
            out_q.chan <= grant;
            last       <= grant;
        end else if (output_ack) begin
            full <= 1'b0;
        end
    end

    // lock_cnt counts words still owed to the current burst owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock     <= 1'b0;
            lock_cnt <= '0;
        end else if (accept) begin
            if (!lock) begin
                lock     <= (LOCK_WORDS > 1);
                lock_cnt <= CNT_W'(LOCK_WORDS - 1);
            end else if (lock_cnt == CNT_W'(1)) begin
                lock     <= 1'b0;
                lock_cnt <= '0;
            end else begin
                lock_cnt <= lock_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (exception_in[i]) low_idx = CH_W'(i);
        end
    end

    // Clear wins over a simultaneous new fault; the source stays frozen while set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exception     <= 1'b0;
            exception_src <= '0;
        end else if (exception_clear) begin
            exception <= 1'b0;
        end else if (!exception && (|exception_in)) begin
            exception     <= 1'b1;
            exception_src <= low_idx;
        end
    end

    assign output_stb  = full;
    assign output_data = out_q.data;
    assign output_chan = out_q.chan;

endmodule
